spi_ram_ctrl: RTL and testbench

Single-port RAM with a command decoder, sitting directly downstream of the SPI slave interface. It consumes each 10-bit frame the slave delivers on `din`/`rx_valid` and decodes the top two bits as a command. It performs address loads, writes and reads against an internal byte-wide memory. Read results return on `dout`/`tx_valid`, and the slave serialises them onto MISO.

---
 rtl/spi_ram_ctrl_if.sv | 11 +
 rtl/spi_ram_ctrl.sv | 84 ++++++++
 tb/tb_spi_ram_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_ctrl_if.sv
// rtl/spi_ram_ctrl_if.sv - frame/read-data bundle between the SPI slave and the RAM controller
// master: SPI slave side (drives frames), slave: RAM controller side (drives read data).
interface spi_ram_ctrl_if;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;

   modport master (output din, output rx_valid, input dout, input tx_valid);
   modport slave  (input din, input rx_valid, output dout, output tx_valid);
endinterface

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoding byte RAM behind an SPI slave
// Each rising edge of rx_valid executes one 2-bit command from the frame.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 0
) (
   input  logic          clk,
   input  logic          rst,
   spi_ram_ctrl_if.slave bus
);
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   logic [7:0]           mem_q [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]           dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 rx_valid_q;
   logic                 accept;
   logic                 mem_we;
   logic [ADDR_SIZE-1:0] payload_addr;

   // rx_valid_q resets high so a frame already present at reset release is ignored.
   assign accept       = bus.rx_valid & ~rx_valid_q;
   assign payload_addr = bus.din[ADDR_SIZE-1:0];

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      tx_valid_d = tx_valid_q;
      mem_we     = 1'b0;
      if (accept) begin
         case (bus.din[9:8])
            CMD_WR_ADDR: begin
               wr_addr_d  = payload_addr;
               tx_valid_d = 1'b0;
            end
            CMD_WR_DATA: begin
               mem_we     = 1'b1;
               tx_valid_d = 1'b0;
               if (AUTO_INC != 0) wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
            end
            CMD_RD_ADDR: begin
               rd_addr_d  = payload_addr;
               tx_valid_d = 1'b0;
            end
            default: begin
               dout_d     = mem_q[rd_addr_q];
               tx_valid_d = 1'b1;
               if (AUTO_INC != 0) rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= 8'h00;
         tx_valid_q <= 1'b0;
         rx_valid_q <= 1'b1;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         rx_valid_q <= bus.rx_valid;
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_addr_q] <= bus.din[7:0];
   end

   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - self-checking bench for spi_ram_ctrl over three configurations
// The same frame stream drives all three instances; a per-instance model predicts outputs.
module tb_spi_ram_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] din = '0;
   logic       rx_valid = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spi_ram_ctrl_if if0 ();
   spi_ram_ctrl_if if1 ();
   spi_ram_ctrl_if if2 ();
   assign if0.din = din;  assign if0.rx_valid = rx_valid;
   assign if1.din = din;  assign if1.rx_valid = rx_valid;
   assign if2.din = din;  assign if2.rx_valid = rx_valid;

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   spi_ram_ctrl #(.MEM_DEPTH(16),  .ADDR_SIZE(4), .AUTO_INC(0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   logic [7:0] act_dout [3];
   logic       act_tx   [3];
   assign act_dout[0] = if0.dout;  assign act_tx[0] = if0.tx_valid;
   assign act_dout[1] = if1.dout;  assign act_tx[1] = if1.tx_valid;
   assign act_dout[2] = if2.dout;  assign act_tx[2] = if2.tx_valid;

   // Reference model: one entry per instance.
   int         depth [3] = '{256, 256, 16};
   int         inc   [3] = '{0, 1, 0};
   logic [7:0] m_mem   [3][256];
   bit         m_known [3][256];
   int         m_wa [3];
   int         m_ra [3];
   logic [7:0] m_dout [3];
   bit         m_dk [3];
   bit         m_tx [3];

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_wa[k] = 0; m_ra[k] = 0; m_dout[k] = 8'h00; m_dk[k] = 1'b1; m_tx[k] = 1'b0;
      end
   endfunction

   function automatic void model_frame(logic [9:0] f);
      int pay;
      pay = int'(f[7:0]);
      for (int k = 0; k < 3; k++) begin
         case (f[9:8])
            2'b00: begin m_wa[k] = pay % depth[k]; m_tx[k] = 1'b0; end
            2'b01: begin
               m_mem[k][m_wa[k]] = f[7:0];
               m_known[k][m_wa[k]] = 1'b1;
               if (inc[k] != 0) m_wa[k] = (m_wa[k] + 1) % depth[k];
               m_tx[k] = 1'b0;
            end
            2'b10: begin m_ra[k] = pay % depth[k]; m_tx[k] = 1'b0; end
            default: begin
               m_dout[k] = m_mem[k][m_ra[k]];
               m_dk[k]   = m_known[k][m_ra[k]];
               m_tx[k]   = 1'b1;
               if (inc[k] != 0) m_ra[k] = (m_ra[k] + 1) % depth[k];
            end
         endcase
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s dut%0d tx_valid", tag, k), 32'(act_tx[k]), 32'(m_tx[k]));
         if (m_dk[k]) check($sformatf("%s dut%0d dout", tag, k), 32'(act_dout[k]), 32'(m_dout[k]));
      end
   endtask

   // Called at posedge+1 with rx_valid low already registered; returns in the same state.
   task automatic send_frame(input logic [9:0] f, input int hold);
      din = f;
      rx_valid = 1'b1;
      model_frame(f);
      @(posedge clk); #1;
      check_all($sformatf("accept %03h", f));
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         check_all($sformatf("hold %03h", f));
      end
      rx_valid = 1'b0;
      @(posedge clk); #1;
      check_all($sformatf("gap %03h", f));
   endtask

   typedef struct {
      logic [9:0] f;
      logic [7:0] exp_dout;
      logic       exp_tx;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic [9:0] rf;
      logic [1:0] rcmd;
      logic [7:0] rpay;
      int         rhold;

      vecs[0] = '{10'h005, 8'h00, 1'b0};
      vecs[1] = '{10'h1A5, 8'h00, 1'b0};
      vecs[2] = '{10'h205, 8'h00, 1'b0};
      vecs[3] = '{10'h300, 8'hA5, 1'b1};

      for (int k = 0; k < 3; k++)
         for (int a = 0; a < 256; a++) begin m_known[k][a] = 1'b0; m_mem[k][a] = 8'h00; end
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset dut%0d dout", k), 32'(act_dout[k]), 32'h0);
         check($sformatf("reset dut%0d tx_valid", k), 32'(act_tx[k]), 32'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic write then read back, checked against fixed vectors on dut0.
      for (int i = 0; i < 4; i++) begin
         din = vecs[i].f;
         rx_valid = 1'b1;
         model_frame(vecs[i].f);
         @(posedge clk); #1;
         check($sformatf("vec%0d dout", i), 32'(if0.dout), 32'(vecs[i].exp_dout));
         check($sformatf("vec%0d tx_valid", i), 32'(if0.tx_valid), 32'(vecs[i].exp_tx));
         check_all($sformatf("vec%0d", i));
         rx_valid = 1'b0;
         @(posedge clk); #1;
      end

      // tx_valid clears on RD_ADDR while dout holds.
      send_frame(10'h210, 1);
      check("clear tx_valid", 32'(if0.tx_valid), 32'h0);
      check("clear dout held", 32'(if0.dout), 32'hA5);

      // Held rx_valid: one write only; mem[1] preloaded so a stray write is visible.
      send_frame(10'h001, 1);
      send_frame(10'h177, 1);
      send_frame(10'h000, 1);
      send_frame(10'h111, 12);
      send_frame(10'h201, 1);
      send_frame(10'h300, 3);
      check("held mem1 untouched", 32'(if1.dout), 32'h77);
      send_frame(10'h122, 1);
      send_frame(10'h200, 1);
      send_frame(10'h300, 1);
      check("held mem0", 32'(if1.dout), 32'h11);
      send_frame(10'h300, 1);
      check("held next wr_addr", 32'(if1.dout), 32'h22);

      // Auto-increment wrap at the top of memory.
      send_frame(10'h0FF, 1);
      send_frame(10'h101, 1);
      send_frame(10'h102, 1);
      send_frame(10'h2FF, 1);
      send_frame(10'h300, 1);
      check("wrap first read", 32'(if1.dout), 32'h01);
      send_frame(10'h300, 1);
      check("wrap second read", 32'(if1.dout), 32'h02);
      check("wrap tx_valid", 32'(if1.tx_valid), 32'h1);

      // Small memory ignores payload bits above the address width.
      send_frame(10'h023, 1);
      send_frame(10'h15C, 1);
      send_frame(10'h203, 1);
      send_frame(10'h300, 1);
      check("small mem dout", 32'(if2.dout), 32'h5C);

      // Reset with rx_valid high: the pending write must not happen.
      send_frame(10'h000, 1);
      send_frame(10'h13C, 1);
      send_frame(10'h200, 1);
      send_frame(10'h300, 1);
      din = 10'h1FF;
      rx_valid = 1'b1;
      #1 rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("mid rst dut%0d dout", k), 32'(act_dout[k]), 32'h0);
         check($sformatf("mid rst dut%0d tx_valid", k), 32'(act_tx[k]), 32'h0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check_all("rst release held");
      end
      rx_valid = 1'b0;
      @(posedge clk); #1;
      send_frame(10'h200, 1);
      send_frame(10'h300, 1);
      check("no write during reset", 32'(if0.dout), 32'h3C);
      send_frame(10'h1FF, 1);
      send_frame(10'h200, 1);
      send_frame(10'h300, 1);
      check("frame after release", 32'(if0.dout), 32'hFF);

      // Random frames against the model.
      for (int i = 0; i < 300; i++) begin
         rcmd  = 2'($urandom_range(0, 3));
         rpay  = 8'($urandom);
         rhold = $urandom_range(1, 3);
         rf    = {rcmd, rpay};
         send_frame(rf, rhold);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
